alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU opcode/operand interface.
- Accepts commands (opcode, A, B, tag) over a valid/ready port and buffers them in a small FIFO.
- Drives them one at a time onto the ALU's opcode/A/B inputs and holds them stable for a fixed pipeline latency.
- Captures the ALU result and returns it with its tag over a valid/ready response port. It sits between the command source (host/testbench sequencer) and the Alu block.

Parameters:
- DATA_WIDTH, 1024, width of operands and result.
- TAG_WIDTH, 4, width of the command tag echoed on the response.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- ALU_LATENCY, 3, rising edges from the first edge at which ALU inputs are valid to the edge at which the ALU result is sampled; ≥1.

Ports:
- clk  in  1  Clock; all logic on rising edge.
- rst  in  1  Reset, asynchronous, active-high.
- cmd_valid  in  1  Command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_opcode  in  3  0=PARITY, 1=POPCOUNT, 2=ROTR, 3=ROTL, 4-7 illegal.
- cmd_a  in  DATA_WIDTH  Operand A.
- cmd_b  in  DATA_WIDTH  Operand B (rotate magnitude).
- cmd_tag  in  TAG_WIDTH  Command tag.
- alu_opcode  out  3  To Alu opcode; registered.
- alu_a  out  DATA_WIDTH  To Alu A_in; registered.
- alu_b  out  DATA_WIDTH  To Alu B_in; registered.
- alu_result  in  DATA_WIDTH  From Alu Alu_out.
- rsp_valid  out  1  Response held.
- rsp_ready  in  1  Consumer accepts response.
- rsp_data  out  DATA_WIDTH  Captured result; zero for illegal opcode.
- rsp_tag  out  TAG_WIDTH  Tag of the command.
- rsp_err  out  1  1 = illegal opcode, not issued.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- **Reset (async, rst=1):**
  - FIFO emptied; FSM to IDLE; cmd_ready=1 once rst falls.
  - alu_opcode=IDLE_OP (3'b111); alu_a=0, alu_b=0.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, busy=0.
  - Reset mid-operation discards the in-flight command and all queued commands; no response is produced.
- **Command push:** occurs when cmd_valid && cmd_ready at an edge. cmd_ready = !full, combinational from FIFO count only (no dependence on cmd_valid). A push and a pop in the same cycle are both allowed when full or empty-with-push is not involved; push to a full FIFO is impossible since cmd_ready=0.
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:**
  - If FIFO non-empty: pop the head.
  - Legal opcode: load alu_opcode/alu_a/alu_b, load cnt=ALU_LATENCY, go to BUSY.
  - Illegal opcode: keep alu_opcode=IDLE_OP, set rsp_data=0, rsp_err=1, rsp_tag, rsp_valid=1, go to RESP (ALU never issued).
- **BUSY:**
  - alu_opcode/alu_a/alu_b are held constant, because the ALU output mux follows opcode.
  - cnt decrements each edge.
  - At the edge where cnt==1: rsp_data<=alu_result, rsp_tag, rsp_err<=0, rsp_valid<=1, alu_opcode<=IDLE_OP, go to RESP.
  - Latency: with the issue at edge E0, capture happens at edge E0+ALU_LATENCY and rsp_valid is visible after that edge.
- **RESP:**
  - rsp_* held stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid<=0. If the FIFO is non-empty in the same cycle, pop and issue immediately (same transitions as IDLE, i.e. back-to-back issue with no idle cycle); else go to IDLE.
- **Ordering:** strictly FIFO; exactly one command in flight; responses are in command order.
- **FIFO pointers:** log2(FIFO_DEPTH)-bit pointers with wrap-around, plus a separate count register of log2(FIFO_DEPTH)+1 bits to distinguish full from empty.
- **busy:** = (count!=0) || state!=IDLE, registered-consistent (derived from registered state).

Decomposition:
- **Package alu_pkg:**
  - Opcode constants PARITY=3'b000, POPCOUNT=3'b001, ROTR=3'b010, ROTL=3'b011, IDLE_OP=3'b111.
  - An is_legal_op function.
  - An FSM state enum {IDLE, BUSY, RESP}.
- **One sub-module: cmd_fifo.** Synchronous FIFO, parameterised on width (3+2*DATA_WIDTH+TAG_WIDTH) and depth, with push/pop/full/empty/count and an async active-high reset.

Test Plan:
(Bench uses DATA_WIDTH=16, ALU_LATENCY=3, and an ALU model whose output equals A^B delayed 3 edges.)
- Single command op=1, A=16'h00F0, B=16'h0F00, tag=5, rsp_ready=1 -> rsp_valid rises exactly 3 edges after the issue edge; rsp_data=16'h0FF0, rsp_tag=5, rsp_err=0; alu_opcode returns to 3'b111.
- Four commands pushed back-to-back (tags 1-4) with rsp_ready=1 -> cmd_ready=0 after the 4th push only if none popped yet; responses arrive in tag order 1,2,3,4, with issue following each handshake with no idle cycle.
- Illegal op=6, tag=9 -> response on the cycle after the pop with rsp_err=1, rsp_data=0, rsp_tag=9; alu_opcode never leaves 3'b111.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_data/tag stable, the next queued command is not issued, and alu_opcode stays 3'b111 until the handshake.
- rst asserted asynchronously (mid-clock) during BUSY with 2 commands queued -> outputs return to reset values immediately; no response follows release; busy=0, cmd_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcode encodings, legality check and issuer FSM states.
package alu_pkg;
  localparam logic [2:0] PARITY   = 3'b000;
  localparam logic [2:0] POPCOUNT = 3'b001;
  localparam logic [2:0] ROTR     = 3'b010;
  localparam logic [2:0] ROTL     = 3'b011;
  localparam logic [2:0] IDLE_OP  = 3'b111;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op inside {PARITY, POPCOUNT, ROTR, ROTL};
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with wrapping pointers and a separate occupancy count.
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] count_q, count_d;
  logic do_push, do_pop;
  assign full_o  = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
  always_comb count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= do_push ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= do_pop ? rptr_q + AW'(1) : rptr_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues one at a time, holds operands
// for the ALU latency and returns the tagged result over a valid/ready port.
module alu_cmd_issuer #(
  parameter int DATA_WIDTH  = 1024,
  parameter int TAG_WIDTH   = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int ALU_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  rsp_err,
  output logic                  busy
);
  import alu_pkg::*;
  localparam int FW = 3 + 2*DATA_WIDTH + TAG_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ALU_LATENCY + 1);
  logic [FW-1:0] head;
  logic full, empty, pop, legal;
  logic [AW:0] count;
  logic [2:0] h_op;
  logic [DATA_WIDTH-1:0] h_a, h_b;
  logic [TAG_WIDTH-1:0] h_tag;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

  cmd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && !full),
    .pop_i   (pop),
    .wdata_i ({cmd_opcode, cmd_a, cmd_b, cmd_tag}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign {h_op, h_a, h_b, h_tag} = head;
  assign legal = is_legal_op(h_op);
  // A held response must be consumed before the next command can leave the queue.
  assign pop = !empty && (state_q == IDLE || (state_q == RESP && rsp_ready));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == BUSY) ? ((cnt_q == CW'(1)) ? RESP : BUSY)
            : (state_q == RESP && !rsp_ready) ? RESP
            : pop ? (legal ? BUSY : RESP) : IDLE;
  end

  always_comb begin
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    if (pop && legal) begin
      alu_op_d = h_op;
      alu_a_d  = h_a;
      alu_b_d  = h_b;
      tag_d    = h_tag;
      cnt_d    = CW'(ALU_LATENCY);
    end else if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = '0;
      rsp_tag_d   = h_tag;
      rsp_err_d   = 1'b1;
    end
    if (state_q == BUSY) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_result;
        rsp_tag_d   = tag_q;
        rsp_err_d   = 1'b0;
        alu_op_d    = IDLE_OP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op_q    <= IDLE_OP;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready  = !full;
  assign alu_opcode = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (count != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed tests of the ALU command issuer against an XOR ALU model.
module tb_alu_cmd_issuer;
  localparam int DW = 16;
  localparam int TW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_ready = 1'b0;
  logic [2:0] cmd_opcode = '0, alu_opcode;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0, alu_a, alu_b, alu_result, rsp_data;
  logic [TW-1:0] cmd_tag = '0, rsp_tag;
  logic rsp_valid, rsp_err, busy;
  logic [DW-1:0] p1 = '0, p2 = '0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // ALU model: A^B, sampled by the issuer on the third edge after issue
  always @(posedge clk) begin
    p1 <= alu_a ^ alu_b;
    p2 <= p1;
  end
  assign alu_result = p2;

  alu_cmd_issuer #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(4), .ALU_LATENCY(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic push(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int n = 0;
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL push_ready: got %b expected 1", cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int m);
    m = 0;
    while (rsp_valid !== 1'b1 && m < 20) begin @(posedge clk); #1; m++; end
  endtask

  task automatic test_reset;
    #12;
    tests++; if (alu_opcode !== 3'b111) begin fails++; $display("FAIL reset_opcode: got %h expected 7", alu_opcode); end
    tests++; if ({alu_a, alu_b} !== '0) begin fails++; $display("FAIL reset_ab: got %h expected 0", {alu_a, alu_b}); end
    tests++; if ({rsp_valid, rsp_err, rsp_tag, rsp_data} !== '0) begin fails++; $display("FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_err, rsp_tag, rsp_data}); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_single;
    int n = 0, m;
    rsp_ready = 1'b1;
    push(3'd1, 16'h00F0, 16'h0F00, 4'd5);
    while (alu_opcode === 3'b111 && n < 10) begin @(posedge clk); #1; n++; end
    tests++; if (n !== 1) begin fails++; $display("FAIL single_issue_delay: got %0d expected 1", n); end
    tests++; if ({alu_opcode, alu_a, alu_b} !== {3'd1, 16'h00F0, 16'h0F00}) begin fails++; $display("FAIL single_alu_inputs: got %h expected %h", {alu_opcode, alu_a, alu_b}, {3'd1, 16'h00F0, 16'h0F00}); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b expected 1", busy); end
    wait_rsp(m);
    tests++; if (m !== 3) begin fails++; $display("FAIL single_latency: got %0d expected 3", m); end
    tests++; if ({rsp_data, rsp_tag, rsp_err} !== {16'h0FF0, 4'd5, 1'b0}) begin fails++; $display("FAIL single_rsp: got %h/%h/%b expected 0ff0/5/0", rsp_data, rsp_tag, rsp_err); end
    tests++; if (alu_opcode !== 3'b111) begin fails++; $display("FAIL single_opcode_idle: got %h expected 7", alu_opcode); end
    @(posedge clk); #1;
    tests++; if ({rsp_valid, busy} !== 2'b00) begin fails++; $display("FAIL single_done: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b1;
    push(3'd6, 16'h1234, 16'h5678, 4'd9);
    @(posedge clk); #1;
    tests++; if ({rsp_valid, rsp_err, rsp_tag, rsp_data} !== {1'b1, 1'b1, 4'd9, 16'h0000}) begin fails++; $display("FAIL illegal_rsp: got v=%b e=%b t=%h d=%h expected 1 1 9 0000", rsp_valid, rsp_err, rsp_tag, rsp_data); end
    tests++; if (alu_opcode !== 3'b111) begin fails++; $display("FAIL illegal_opcode: got %h expected 7", alu_opcode); end
    @(posedge clk); #1;
    tests++; if ({rsp_valid, busy, alu_opcode} !== {2'b00, 3'b111}) begin fails++; $display("FAIL illegal_done: got v=%b busy=%b op=%h expected 0 0 7", rsp_valid, busy, alu_opcode); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [DW-1:0] av [4] = '{16'h0001, 16'h00FF, 16'hA5A5, 16'hFFFF};
    logic [DW-1:0] bv [4] = '{16'h0100, 16'hFF00, 16'h5A5A, 16'h1234};
    logic [DW-1:0] xv [4] = '{16'h0101, 16'hFFFF, 16'hFFFF, 16'hEDCB};
    int m;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_opcode = ops[i]; cmd_a = av[i]; cmd_b = bv[i]; cmd_tag = TW'(i + 1);
      tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL b2b_push_ready%0d: got %b expected 1", i, cmd_ready); end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests++; if ({cmd_ready, busy} !== 2'b11) begin fails++; $display("FAIL b2b_after_push: got ready=%b busy=%b expected 1 1", cmd_ready, busy); end
    for (int i = 0; i < 4; i++) begin
      wait_rsp(m);
      tests++; if (m !== ((i == 0) ? 1 : 3)) begin fails++; $display("FAIL b2b_latency%0d: got %0d expected %0d", i, m, (i == 0) ? 1 : 3); end
      tests++; if ({rsp_tag, rsp_data, rsp_err} !== {TW'(i + 1), xv[i], 1'b0}) begin fails++; $display("FAIL b2b_rsp%0d: got %h/%h/%b expected %h/%h/0", i, rsp_tag, rsp_data, rsp_err, i + 1, xv[i]); end
      @(posedge clk); #1;
      tests++; if (alu_opcode !== ((i < 3) ? ops[(i + 1) % 4] : 3'b111)) begin fails++; $display("FAIL b2b_next_issue%0d: got %h expected %h", i, alu_opcode, (i < 3) ? ops[(i + 1) % 4] : 3'b111); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop%0d: got %b expected 0", i, rsp_valid); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure;
    logic [2:0] ops [4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    logic [DW-1:0] av [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [DW-1:0] xv [4] = '{16'h10FF, 16'h20FF, 16'h30FF, 16'h40FF};
    int m;
    rsp_ready = 1'b0;
    push(3'd2, 16'hF00F, 16'h0004, 4'd3);
    wait_rsp(m);
    tests++; if (m !== 4) begin fails++; $display("FAIL bp_latency: got %0d expected 4", m); end
    tests++; if ({rsp_tag, rsp_data} !== {4'd3, 16'hF00B}) begin fails++; $display("FAIL bp_rsp: got %h/%h expected 3/f00b", rsp_tag, rsp_data); end
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_opcode = ops[i]; cmd_a = av[i]; cmd_b = 16'h00FF; cmd_tag = TW'(10 + i);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests++; if ({cmd_ready, busy} !== 2'b01) begin fails++; $display("FAIL bp_full: got ready=%b busy=%b expected 0 1", cmd_ready, busy); end
    for (int i = 0; i < 6; i++) begin
      tests++; if ({rsp_valid, rsp_tag, rsp_data, alu_opcode} !== {1'b1, 4'd3, 16'hF00B, 3'b111}) begin fails++; $display("FAIL bp_hold%0d: got v=%b t=%h d=%h op=%h expected 1 3 f00b 7", i, rsp_valid, rsp_tag, rsp_data, alu_opcode); end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if ({rsp_valid, alu_opcode, alu_a, cmd_ready} !== {1'b0, 3'd3, 16'h1000, 1'b1}) begin fails++; $display("FAIL bp_release: got v=%b op=%h a=%h rdy=%b expected 0 3 1000 1", rsp_valid, alu_opcode, alu_a, cmd_ready); end
    for (int i = 0; i < 4; i++) begin
      wait_rsp(m);
      tests++; if (m !== 3) begin fails++; $display("FAIL bp_drain_latency%0d: got %0d expected 3", i, m); end
      tests++; if ({rsp_tag, rsp_data} !== {TW'(10 + i), xv[i]}) begin fails++; $display("FAIL bp_drain_rsp%0d: got %h/%h expected %h/%h", i, rsp_tag, rsp_data, 10 + i, xv[i]); end
      @(posedge clk); #1;
      tests++; if (alu_opcode !== ((i < 3) ? ops[(i + 1) % 4] : 3'b111)) begin fails++; $display("FAIL bp_next_issue%0d: got %h expected %h", i, alu_opcode, (i < 3) ? ops[(i + 1) % 4] : 3'b111); end
    end
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_opcode = 3'd1; cmd_a = 16'hBEEF; cmd_b = 16'h0001; cmd_tag = TW'(i + 1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    tests++; if ({busy, alu_opcode} !== {1'b1, 3'd1}) begin fails++; $display("FAIL rstmid_pre: got busy=%b op=%h expected 1 1", busy, alu_opcode); end
    #3 rst = 1'b1;
    #1;
    tests++; if ({alu_opcode, alu_a, alu_b} !== {3'b111, 32'h0}) begin fails++; $display("FAIL rstmid_alu: got %h/%h/%h expected 7/0/0", alu_opcode, alu_a, alu_b); end
    tests++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin fails++; $display("FAIL rstmid_flags: got v=%b busy=%b rdy=%b expected 0 0 1", rsp_valid, busy, cmd_ready); end
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      tests++; if ({rsp_valid, alu_opcode} !== {1'b0, 3'b111}) begin fails++; $display("FAIL rstmid_quiet%0d: got v=%b op=%h expected 0 7", i, rsp_valid, alu_opcode); end
    end
    tests++; if ({busy, cmd_ready} !== 2'b01) begin fails++; $display("FAIL rstmid_after: got busy=%b rdy=%b expected 0 1", busy, cmd_ready); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_illegal;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
